// File: rtl/tx_port_pkg.sv
// Shared types and helpers for the 64-bit TX port writer.
package tx_port_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACK,
      WRITE,
      WAIT_DROP
   } state_t;

   localparam int C_DATA_WIDTH     = 64;
   localparam int C_WORDS_PER_BEAT = 2;

   // Channel lengths are in 32-bit words; a trailing odd word still costs a full beat.
   function automatic logic [31:0] beats_from_words(input logic [31:0] len);
      logic [31:0] whole;
      logic [31:0] partial;
      whole   = len / 32'(C_WORDS_PER_BEAT);
      partial = ((len % 32'(C_WORDS_PER_BEAT)) != 32'd0) ? 32'd1 : 32'd0;
      return whole + partial;
   endfunction

endpackage

// File: rtl/tx_port_beat_counter.sv
// Loadable down-counter tracking beats still to be accepted from the channel.
module tx_port_beat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         is_zero,
   output logic         is_one
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign is_zero = (count == '0);
   assign is_one  = (count == W'(1));

endmodule

// File: rtl/tx_port_writer_64.sv
// Moves one channel transaction's 64-bit beats into the TX buffer FIFO,
// announcing the length to the buffer and the transaction to the request logic.
module tx_port_writer_64 #(
   parameter int C_DATA_WIDTH       = tx_port_pkg::C_DATA_WIDTH,
   parameter int C_FIFO_DEPTH       = 512,
   parameter int C_FIFO_DEPTH_WIDTH = $clog2((2**$clog2(C_FIFO_DEPTH))+1),
   parameter int C_HEADROOM         = 3
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          CHNL_TX,
   output logic                          CHNL_TX_ACK,
   input  logic                          CHNL_TX_LAST,
   input  logic [31:0]                   CHNL_TX_LEN,
   input  logic [30:0]                   CHNL_TX_OFF,
   input  logic [C_DATA_WIDTH-1:0]       CHNL_TX_DATA,
   input  logic                          CHNL_TX_DATA_VALID,
   output logic                          CHNL_TX_DATA_REN,
   output logic                          LEN_VALID,
   output logic                          LEN_LSB,
   output logic                          LEN_LAST,
   output logic [C_DATA_WIDTH-1:0]       WR_DATA,
   output logic                          WR_EN,
   input  logic [C_FIFO_DEPTH_WIDTH-1:0] WR_COUNT,
   output logic                          TXN_VALID,
   output logic [31:0]                   TXN_LEN,
   output logic [30:0]                   TXN_OFF,
   output logic                          TXN_LAST
);

   import tx_port_pkg::*;

   localparam int HALF = C_DATA_WIDTH / 2;

   state_t                    state;
   state_t                    state_next;
   logic [31:0]               len_q;
   logic [30:0]               off_q;
   logic                      last_q;
   logic                      ren_q;
   logic                      ren_d;
   logic                      wr_en_q;
   logic [C_DATA_WIDTH-1:0]   wr_data_q;
   logic [31:0]               load_beats;
   logic                      cnt_zero;
   logic                      cnt_one;
   logic                      room;
   logic                      accept;

   assign load_beats = beats_from_words(len_q);
   assign room       = (32'(WR_COUNT) + 32'(C_HEADROOM)) < 32'(C_FIFO_DEPTH);
   assign accept     = (state == WRITE) && ren_q && CHNL_TX_DATA_VALID;

   tx_port_beat_counter #(
      .W (32)
   ) beat_counter (
      .clk        (CLK),
      .rst_n      (RST),
      .load       (state == ACK),
      .load_value (load_beats),
      .dec        (accept),
      .is_zero    (cnt_zero),
      .is_one     (cnt_one)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         ren_q <= 1'b0;
      end else begin
         state <= state_next;
         ren_q <= ren_d;
      end
   end

   // REN is only granted for beats still owed, so the channel is never over-read.
   always_comb begin
      state_next = state;
      ren_d      = 1'b0;
      case (state)
         IDLE: begin
            if (CHNL_TX) state_next = ACK;
         end
         ACK: begin
            state_next = (load_beats == 32'd0) ? WAIT_DROP : WRITE;
            ren_d      = (load_beats != 32'd0) && room;
         end
         WRITE: begin
            if (accept && cnt_one) state_next = WAIT_DROP;
            ren_d = ((!cnt_zero && !cnt_one) || (cnt_one && !accept)) && room;
         end
         WAIT_DROP: begin
            if (!CHNL_TX) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         len_q  <= '0;
         off_q  <= '0;
         last_q <= 1'b0;
      end else if ((state == IDLE) && CHNL_TX) begin
         len_q  <= CHNL_TX_LEN;
         off_q  <= CHNL_TX_OFF;
         last_q <= CHNL_TX_LAST;
      end
   end

   // An odd word count leaves the top half of the final beat as padding.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= accept;
         if (accept) begin
            if (cnt_one && len_q[0]) begin
               wr_data_q <= {{HALF{1'b0}}, CHNL_TX_DATA[HALF-1:0]};
            end else begin
               wr_data_q <= CHNL_TX_DATA;
            end
         end
      end
   end

   assign CHNL_TX_ACK      = (state == ACK);
   assign LEN_VALID        = (state == ACK);
   assign TXN_VALID        = (state == ACK);
   assign LEN_LSB          = len_q[0];
   assign LEN_LAST         = last_q;
   assign TXN_LEN          = len_q;
   assign TXN_OFF          = off_q;
   assign TXN_LAST         = last_q;
   assign CHNL_TX_DATA_REN = ren_q;
   assign WR_EN            = wr_en_q;
   assign WR_DATA          = wr_data_q;

endmodule

// File: tb/tb_tx_port_writer_64.sv
// Self-checking bench for tx_port_writer_64: vector table, reset sequence and random transactions.
module tb_tx_port_writer_64;

   localparam int DEPTH = 512;
   localparam int CW    = $clog2((2**$clog2(DEPTH))+1);

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          CHNL_TX = 1'b0;
   logic          CHNL_TX_ACK;
   logic          CHNL_TX_LAST = 1'b0;
   logic [31:0]   CHNL_TX_LEN = '0;
   logic [30:0]   CHNL_TX_OFF = '0;
   logic [63:0]   CHNL_TX_DATA = '0;
   logic          CHNL_TX_DATA_VALID = 1'b0;
   logic          CHNL_TX_DATA_REN;
   logic          LEN_VALID;
   logic          LEN_LSB;
   logic          LEN_LAST;
   logic [63:0]   WR_DATA;
   logic          WR_EN;
   logic [CW-1:0] WR_COUNT = '0;
   logic          TXN_VALID;
   logic [31:0]   TXN_LEN;
   logic [30:0]   TXN_OFF;
   logic          TXN_LAST;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fifo_occ  = 0;

   always #5 CLK = ~CLK;

   tx_port_writer_64 #(
      .C_DATA_WIDTH (64),
      .C_FIFO_DEPTH (DEPTH),
      .C_HEADROOM   (3)
   ) dut (
      .CLK                (CLK),
      .RST                (RST),
      .CHNL_TX            (CHNL_TX),
      .CHNL_TX_ACK        (CHNL_TX_ACK),
      .CHNL_TX_LAST       (CHNL_TX_LAST),
      .CHNL_TX_LEN        (CHNL_TX_LEN),
      .CHNL_TX_OFF        (CHNL_TX_OFF),
      .CHNL_TX_DATA       (CHNL_TX_DATA),
      .CHNL_TX_DATA_VALID (CHNL_TX_DATA_VALID),
      .CHNL_TX_DATA_REN   (CHNL_TX_DATA_REN),
      .LEN_VALID          (LEN_VALID),
      .LEN_LSB            (LEN_LSB),
      .LEN_LAST           (LEN_LAST),
      .WR_DATA            (WR_DATA),
      .WR_EN              (WR_EN),
      .WR_COUNT           (WR_COUNT),
      .TXN_VALID          (TXN_VALID),
      .TXN_LEN            (TXN_LEN),
      .TXN_OFF            (TXN_OFF),
      .TXN_LAST           (TXN_LAST)
   );

   typedef struct {
      logic [31:0] len;
      logic [30:0] off;
      logic        last;
      int          vmode;
      int          drain_pct;
      int          hold;
      int          exp_beats;
   } vec_t;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int model_beats(input logic [31:0] len);
      longint l;
      l = longint'(len);
      return int'((l + 1) / 2);
   endfunction

   function automatic logic [63:0] model_beat(input logic [31:0] seed, input int k, input int n, input logic odd);
      logic [63:0] b;
      b = {seed, 32'(k)};
      if ((k == n - 1) && odd) b[63:32] = 32'd0;
      return b;
   endfunction

   // One full transaction: source model feeds beats, FIFO model absorbs writes.
   task automatic applyStimulus(input vec_t v);
      int n, k, wr_idx, ack_cnt, lv_cnt, tv_cnt, ack_cycle;
      int overread, full_viol, late_ren, overflow, extra, budget;
      bit done;
      logic [31:0] seed;
      n = model_beats(v.len);
      seed = $urandom;
      k = 0; wr_idx = 0; ack_cnt = 0; lv_cnt = 0; tv_cnt = 0; ack_cycle = -1;
      overread = 0; full_viol = 0; late_ren = 0; overflow = 0; extra = 0;
      done = 1'b0;
      budget = n * 12 + v.hold + 40;
      @(negedge CLK);
      fifo_occ = 0;
      WR_COUNT = (v.hold > 0) ? CW'(DEPTH - 3) : '0;
      CHNL_TX = 1'b1;
      CHNL_TX_LEN = v.len;
      CHNL_TX_OFF = v.off;
      CHNL_TX_LAST = v.last;
      CHNL_TX_DATA_VALID = 1'b0;
      for (int cyc = 1; cyc <= budget && !done; cyc++) begin
         @(negedge CLK);
         if (CHNL_TX_ACK) begin
            ack_cnt++;
            if (ack_cycle < 0) ack_cycle = cyc;
            checkOutput("len_lsb", LEN_LSB, v.len[0]);
            checkOutput("len_last", LEN_LAST, v.last);
            checkOutput("txn_len", TXN_LEN, v.len);
            checkOutput("txn_off", TXN_OFF, v.off);
            checkOutput("txn_last", TXN_LAST, v.last);
         end
         if (LEN_VALID) lv_cnt++;
         if (TXN_VALID) tv_cnt++;
         if (cyc <= v.hold && (CHNL_TX_DATA_REN || WR_EN)) full_viol++;
         if (WR_EN) begin
            if (wr_idx < n)
               checkOutput($sformatf("beat%0d", wr_idx), WR_DATA, model_beat(seed, wr_idx, n, v.len[0]));
            wr_idx++;
            fifo_occ++;
            if (fifo_occ > DEPTH) overflow++;
         end
         if (ack_cnt > 0 && wr_idx >= n) begin
            if (CHNL_TX_DATA_REN) late_ren++;
            done = 1'b1;
         end
         if (fifo_occ > 0 && $urandom_range(99) < v.drain_pct) fifo_occ--;
         if (cyc >= v.hold) WR_COUNT = CW'(fifo_occ);
         case (v.vmode)
            0:       CHNL_TX_DATA_VALID = 1'b1;
            1:       CHNL_TX_DATA_VALID = (cyc % 2 == 1);
            default: CHNL_TX_DATA_VALID = 1'($urandom_range(1));
         endcase
         CHNL_TX_DATA = {seed, 32'(k)};
         if (CHNL_TX_DATA_REN && CHNL_TX_DATA_VALID) begin
            if (k >= n) overread++;
            k++;
         end
      end
      CHNL_TX = 1'b0;
      CHNL_TX_DATA_VALID = 1'b0;
      repeat (2) begin
         @(negedge CLK);
         if (WR_EN || CHNL_TX_DATA_REN || CHNL_TX_ACK || LEN_VALID) extra++;
      end
      checkOutput("done", done, 1);
      checkOutput("ack_count", ack_cnt, 1);
      checkOutput("len_valid_count", lv_cnt, 1);
      checkOutput("txn_valid_count", tv_cnt, 1);
      checkOutput("ack_latency", ack_cycle, 1);
      checkOutput("beats_written", wr_idx, v.exp_beats);
      checkOutput("over_read", overread, 0);
      checkOutput("ren_while_full", full_viol, 0);
      checkOutput("ren_after_done", late_ren, 0);
      checkOutput("fifo_overflow", overflow, 0);
      checkOutput("activity_after_drop", extra, 0);
   endtask

   initial begin
      vec_t vecs[8];
      vec_t rv;
      vecs[0] = '{len: 32'd8,    off: 31'h10,  last: 1'b1, vmode: 0, drain_pct: 100, hold: 0,  exp_beats: 4};
      vecs[1] = '{len: 32'd5,    off: 31'h22,  last: 1'b0, vmode: 1, drain_pct: 100, hold: 0,  exp_beats: 3};
      vecs[2] = '{len: 32'd0,    off: 31'h7,   last: 1'b1, vmode: 0, drain_pct: 100, hold: 0,  exp_beats: 0};
      vecs[3] = '{len: 32'd3,    off: 31'h100, last: 1'b0, vmode: 0, drain_pct: 100, hold: 0,  exp_beats: 2};
      vecs[4] = '{len: 32'd6,    off: 31'h104, last: 1'b1, vmode: 0, drain_pct: 100, hold: 0,  exp_beats: 3};
      vecs[5] = '{len: 32'd1,    off: 31'h3,   last: 1'b1, vmode: 2, drain_pct: 100, hold: 0,  exp_beats: 1};
      vecs[6] = '{len: 32'd2048, off: 31'h0,   last: 1'b1, vmode: 0, drain_pct: 100, hold: 20, exp_beats: 1024};
      vecs[7] = '{len: 32'd1201, off: 31'h55,  last: 1'b0, vmode: 0, drain_pct: 30,  hold: 0,  exp_beats: 601};

      repeat (3) @(negedge CLK);
      checkOutput("reset_ctrl", {CHNL_TX_ACK, CHNL_TX_DATA_REN, LEN_VALID, LEN_LSB, LEN_LAST, WR_EN, TXN_VALID, TXN_LAST}, 0);
      checkOutput("reset_wr_data", WR_DATA, 0);
      checkOutput("reset_txn_len", TXN_LEN, 0);
      RST = 1'b1;

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Reset asserted in the middle of a LEN=64 transfer.
      @(negedge CLK);
      CHNL_TX = 1'b1;
      CHNL_TX_LEN = 32'd64;
      CHNL_TX_OFF = 31'h5;
      CHNL_TX_LAST = 1'b1;
      CHNL_TX_DATA_VALID = 1'b1;
      CHNL_TX_DATA = 64'hDEAD_BEEF_0123_4567;
      repeat (8) @(negedge CLK);
      checkOutput("mid_transfer_wr_en", WR_EN, 1);
      #2 RST = 1'b0;
      #1;
      checkOutput("rst_ctrl", {CHNL_TX_ACK, CHNL_TX_DATA_REN, LEN_VALID, LEN_LSB, LEN_LAST, WR_EN, TXN_VALID, TXN_LAST}, 0);
      checkOutput("rst_wr_data", WR_DATA, 0);
      checkOutput("rst_txn", {TXN_LEN, TXN_OFF}, 0);
      @(negedge CLK);
      CHNL_TX = 1'b0;
      CHNL_TX_DATA_VALID = 1'b0;
      RST = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         checkOutput("no_wr_after_reset", {WR_EN, CHNL_TX_DATA_REN, CHNL_TX_ACK}, 0);
      end
      rv = '{len: 32'd4, off: 31'h9, last: 1'b0, vmode: 0, drain_pct: 100, hold: 0, exp_beats: 2};
      applyStimulus(rv);

      for (int i = 0; i < 12; i++) begin
         rv.len       = 32'($urandom_range(0, 40));
         rv.off       = 31'($urandom);
         rv.last      = 1'($urandom_range(1));
         rv.vmode     = $urandom_range(0, 2);
         rv.drain_pct = $urandom_range(20, 100);
         rv.hold      = 0;
         rv.exp_beats = model_beats(rv.len);
         applyStimulus(rv);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/tx_port_writer_64.md
Name: tx_port_writer_64

Overview:
- Upstream neighbour of the 64-bit TX port buffer.
- Accepts a user channel transaction (length, offset, last flag) and moves the channel's 64-bit data beats into the buffer FIFO.
- Announces each transfer's length LSB and last flag to the buffer, and publishes the transaction to the TX request logic.
- Applies FIFO backpressure using the buffer's write count.

Parameters:
- C_DATA_WIDTH, 64: data bus width in bits; 64 is the only supported value.
- C_FIFO_DEPTH, 512: depth of the downstream buffer FIFO, in beats.
- C_FIFO_DEPTH_WIDTH, clog2((2**clog2(C_FIFO_DEPTH))+1): width of WR_COUNT.
- C_HEADROOM, 3: free FIFO entries reserved to cover the registered read-enable/write pipeline.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- CHNL_TX  in  1  transaction request; level held high until ACK is seen and all data has been sent.
- CHNL_TX_ACK  out  1  one-cycle pulse acknowledging the request.
- CHNL_TX_LAST  in  1  last transaction of the transfer.
- CHNL_TX_LEN  in  32  transaction length in 32-bit words.
- CHNL_TX_OFF  in  31  offset in 32-bit words.
- CHNL_TX_DATA  in  64  channel data beat.
- CHNL_TX_DATA_VALID  in  1  channel beat valid.
- CHNL_TX_DATA_REN  out  1  channel beat accepted (registered).
- LEN_VALID  out  1  pulse: a transfer length is valid for the buffer.
- LEN_LSB  out  1  bit 0 of the latched length.
- LEN_LAST  out  1  latched last flag.
- WR_DATA  out  64  beat to the buffer FIFO.
- WR_EN  out  1  FIFO write enable.
- WR_COUNT  in  C_FIFO_DEPTH_WIDTH  current FIFO occupancy.
- TXN_VALID  out  1  pulse: transaction published to the request logic.
- TXN_LEN  out  32  latched length.
- TXN_OFF  out  31  latched offset.
- TXN_LAST  out  1  latched last flag.

Behaviour:
- Reset (RST low, asynchronous): state IDLE, all outputs 0, counters 0. Reset mid-transfer discards the partial transaction. No WR_EN is issued after reset until a new CHNL_TX.
- State machine: IDLE -> ACK -> WRITE -> WAIT_DROP -> IDLE.
- IDLE: CHNL_TX sampled high -> latch LEN/OFF/LAST; next state ACK.
- ACK (exactly 1 cycle), all asserted for one cycle:
  - CHNL_TX_ACK=1, LEN_VALID=1, TXN_VALID=1.
  - LEN_LSB=LEN[0], LEN_LAST/TXN_* = latched values.
  - Beat counter loaded with ceil(LEN/2) = (LEN>>1)+LEN[0], 32-bit arithmetic (LEN=0xFFFFFFFF -> 0x80000000 beats).
  - LEN=0 -> WAIT_DROP; otherwise -> WRITE.
- WRITE:
  - Next-cycle CHNL_TX_DATA_REN = (beats_rem > 1, or beats_rem==1 with no accept this cycle) && (WR_COUNT + C_HEADROOM < C_FIFO_DEPTH).
  - Accept = REN && VALID.
  - On accept, the next cycle has WR_EN=1 and WR_DATA=beat, and beats_rem decrements.
  - If it is the final beat and LEN[0]=1, WR_DATA[63:32] is forced to 0.
  - Beats with VALID while REN=0 are not taken. REN never exceeds the remaining beat count (no over-read).
  - beats_rem reaching 0 -> WAIT_DROP.
- WAIT_DROP: REN=0; stay until CHNL_TX is sampled low, then IDLE. CHNL_TX low during WRITE is ignored: the full length is always transferred.
- Back-to-back transactions: CHNL_TX re-asserted the cycle after the drop is sampled in IDLE; minimum gap between ACKs is 3 cycles plus the data beats.
- Throughput: 1 beat/cycle sustained while the FIFO has room.
- Exactly one LEN_VALID per transaction, including zero-length transactions.
- Full boundary: WR_COUNT + C_HEADROOM >= C_FIFO_DEPTH deasserts REN on the next cycle. In-flight beats must never overflow the FIFO.

Decomposition:
- Shared package tx_port_pkg holds:
  - state enum (IDLE, ACK, WRITE, WAIT_DROP);
  - C_DATA_WIDTH and C_WORDS_PER_BEAT=2 constants;
  - function beats_from_words(len).
- One natural sub-module, tx_port_beat_counter: loadable down-counter with zero/one flags.

Test Plan:
- LEN=8, LAST=1, continuous VALID, empty FIFO:
  - ACK + LEN_VALID one cycle, LEN_LSB=0, LEN_LAST=1;
  - 4 WR_EN beats in consecutive cycles, data unchanged; REN deasserts after the 4th accept.
- LEN=5, VALID toggling 1/0:
  - 3 beats written;
  - third WR_DATA[63:32]=0;
  - LEN_LSB=1;
  - no further REN afterwards.
- LEN=0:
  - ACK, LEN_VALID, TXN_VALID with TXN_LEN=0;
  - no REN, no WR_EN;
  - returns to IDLE after CHNL_TX drops.
- LEN=2048 with WR_COUNT held at C_FIFO_DEPTH-3:
  - REN=0 and no WR_EN while held;
  - release to 0 -> transfer resumes;
  - total 1024 beats, never more.
- Assert RST low mid-WRITE of a LEN=64 transfer:
  - outputs 0 immediately;
  - after release, a new LEN=4 transaction completes with exactly 2 beats.
- Two back-to-back transactions, LEN=3 then LEN=6 (LAST=0, then 1):
  - two LEN_VALID pulses with LSB 1, 0 and LAST 0, 1;
  - 2 + 3 beats written.
